// File: rtl/writeback_regfile_pkg.sv
// Shared constants and helpers for the writeback stage register file.
package writeback_regfile_pkg;

    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned XLEN      = 32;

    localparam logic [5:0] OP_JAL = 6'h03;
    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;

    typedef enum logic [1:0] {
        SelAlu,
        SelLoad,
        SelLink
    } resultSel_t;

    function automatic logic [XLEN-1:0] signExtend8(input logic [7:0] b);
        return {{(XLEN-8){b[7]}}, b};
    endfunction

    function automatic logic [XLEN-1:0] signExtend16(input logic [15:0] h);
        return {{(XLEN-16){h[15]}}, h};
    endfunction

endpackage

// File: rtl/writeback_regfile_load_extract.sv
// Combinational load-data lane selection and sign/zero extension.
module load_extract
    import writeback_regfile_pkg::*;
(
    input  logic [XLEN-1:0] rawWord,
    input  logic [1:0]      offset,
    input  logic [5:0]      opcode,
    output logic [XLEN-1:0] value
);

    logic [7:0]  laneByte;
    logic [15:0] laneHalf;

    always_comb begin
        // Little-endian: lane 0 is the least significant byte.
        unique case (offset)
            2'd0:    laneByte = rawWord[7:0];
            2'd1:    laneByte = rawWord[15:8];
            2'd2:    laneByte = rawWord[23:16];
            default: laneByte = rawWord[31:24];
        endcase
        laneHalf = offset[1] ? rawWord[31:16] : rawWord[15:0];
    end

    always_comb begin
        case (opcode)
            OP_LB:   value = signExtend8(laneByte);
            OP_LBU:  value = {{(XLEN-8){1'b0}}, laneByte};
            OP_LH:   value = signExtend16(laneHalf);
            OP_LHU:  value = {{(XLEN-16){1'b0}}, laneHalf};
            default: value = rawWord;
        endcase
    end

endmodule

// File: rtl/writeback_regfile.sv
// Writeback-stage register file with retire counter.
// Define WRITEBACK_REGFILE_BYPASS_EN for same-cycle write-before-read forwarding.
module writeback_regfile #(
    parameter int unsigned NREGS  = 32,
    parameter logic [5:0]  OP_JAL = 6'h03
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RegWriteW,
    input  logic        MemtoRegW,
    input  logic [31:0] ReadDataW,
    input  logic [31:0] ALUOutW,
    input  logic [31:0] returnAddressW,
    input  logic [31:0] instrW,
    input  logic [writeback_regfile_pkg::REG_IDX_W-1:0] WriteRegW,
    input  logic [5:0]  opcodeW,
    input  logic [writeback_regfile_pkg::REG_IDX_W-1:0] ReadReg1,
    input  logic [writeback_regfile_pkg::REG_IDX_W-1:0] ReadReg2,
    output logic [31:0] ReadData1,
    output logic [31:0] ReadData2,
    output logic [31:0] ResultW,
    output logic [31:0] retiredCount
);
    // Explicit imports: the module's own OP_JAL parameter shadows the package constant.
    import writeback_regfile_pkg::REG_IDX_W;
    import writeback_regfile_pkg::resultSel_t;
    import writeback_regfile_pkg::SelAlu;
    import writeback_regfile_pkg::SelLoad;
    import writeback_regfile_pkg::SelLink;

`ifdef WRITEBACK_REGFILE_BYPASS_EN
    localparam bit BypassEn = 1'b1;
`else
    localparam bit BypassEn = 1'b0;
`endif

    logic [31:0] regFile [NREGS];
    logic [31:0] retiredCountQ;
    logic [31:0] loadValue;
    resultSel_t  resultSel;
    logic        writeValid;

    load_extract uLoadExtract (
        .rawWord (ReadDataW),
        .offset  (ALUOutW[1:0]),
        .opcode  (opcodeW),
        .value   (loadValue)
    );

    always_comb begin
        if (opcodeW == OP_JAL) begin
            resultSel = SelLink;
        end else if (MemtoRegW) begin
            resultSel = SelLoad;
        end else begin
            resultSel = SelAlu;
        end
    end

    always_comb begin
        case (resultSel)
            SelLink: ResultW = returnAddressW;
            SelLoad: ResultW = loadValue;
            default: ResultW = ALUOutW;
        endcase
    end

    assign writeValid = RegWriteW && (WriteRegW != '0) && (32'(WriteRegW) < NREGS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regFile[i] <= '0;
            end
            retiredCountQ <= '0;
        end else begin
            if (writeValid) begin
                regFile[WriteRegW] <= ResultW;
            end
            // Retirement is tracked per non-bubble instruction, regardless of writeback.
            if (instrW != '0) begin
                retiredCountQ <= retiredCountQ + 32'd1;
            end
        end
    end

    function automatic logic [31:0] readPort(input logic [REG_IDX_W-1:0] addr);
        if (!rst_n || addr == '0 || 32'(addr) >= NREGS) begin
            return '0;
        end else if (BypassEn && writeValid && addr == WriteRegW) begin
            return ResultW;
        end else begin
            return regFile[addr];
        end
    endfunction

    assign ReadData1    = readPort(ReadReg1);
    assign ReadData2    = readPort(ReadReg2);
    assign retiredCount = retiredCountQ;

endmodule

// File: tb/tb_writeback_regfile.sv
// Randomized self-checking bench for writeback_regfile against a behavioural model.
module tb_writeback_regfile;

    logic        clk;
    logic        rst_n;
    logic        RegWriteW;
    logic        MemtoRegW;
    logic [31:0] ReadDataW;
    logic [31:0] ALUOutW;
    logic [31:0] returnAddressW;
    logic [31:0] instrW;
    logic [4:0]  WriteRegW;
    logic [5:0]  opcodeW;
    logic [4:0]  ReadReg1;
    logic [4:0]  ReadReg2;
    logic [31:0] ReadData1;
    logic [31:0] ReadData2;
    logic [31:0] ResultW;
    logic [31:0] retiredCount;

    int total;
    int bad;

    logic [31:0] mreg [32];
    logic [31:0] mcnt;

    writeback_regfile dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .RegWriteW      (RegWriteW),
        .MemtoRegW      (MemtoRegW),
        .ReadDataW      (ReadDataW),
        .ALUOutW        (ALUOutW),
        .returnAddressW (returnAddressW),
        .instrW         (instrW),
        .WriteRegW      (WriteRegW),
        .opcodeW        (opcodeW),
        .ReadReg1       (ReadReg1),
        .ReadReg2       (ReadReg2),
        .ReadData1      (ReadData1),
        .ReadData2      (ReadData2),
        .ResultW        (ResultW),
        .retiredCount   (retiredCount)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mdlResult();
        logic [31:0] b;
        logic [31:0] h;
        if (opcodeW == 6'h03) return returnAddressW;
        if (!MemtoRegW) return ALUOutW;
        b = (ReadDataW >> (8 * ALUOutW[1:0])) & 32'hFF;
        h = (ReadDataW >> (16 * ALUOutW[1])) & 32'hFFFF;
        case (opcodeW)
            6'h20:   return (b >= 32'h80) ? b + 32'hFFFF_FF00 : b;
            6'h24:   return b;
            6'h21:   return (h >= 32'h8000) ? h + 32'hFFFF_0000 : h;
            6'h25:   return h;
            default: return ReadDataW;
        endcase
    endfunction

    function automatic logic [31:0] mdlRead(input logic [4:0] addr);
        if (!rst_n || addr == 0) return 32'h0;
`ifdef WRITEBACK_REGFILE_BYPASS_EN
        if (RegWriteW && WriteRegW != 0 && addr == WriteRegW) return mdlResult();
`endif
        return mreg[addr];
    endfunction

    task automatic checkAll(input string tag);
        check({tag, ".result"}, ResultW, mdlResult());
        check({tag, ".rd1"}, ReadData1, mdlRead(ReadReg1));
        check({tag, ".rd2"}, ReadData2, mdlRead(ReadReg2));
        check({tag, ".count"}, retiredCount, mcnt);
    endtask

    // Advance one clock edge, updating the model with the pre-edge inputs.
    task automatic tick();
        logic [31:0] res;
        @(posedge clk);
        res = mdlResult();
        if (rst_n) begin
            if (RegWriteW && WriteRegW != 0) mreg[WriteRegW] = res;
            if (instrW != 0) mcnt = mcnt + 32'd1;
        end
        @(negedge clk);
    endtask

    task automatic drive(input logic rw, input logic mtr, input logic [31:0] rd,
                         input logic [31:0] alu, input logic [31:0] ra,
                         input logic [31:0] instr, input logic [4:0] wr, input logic [5:0] op);
        RegWriteW      = rw;
        MemtoRegW      = mtr;
        ReadDataW      = rd;
        ALUOutW        = alu;
        returnAddressW = ra;
        instrW         = instr;
        WriteRegW      = wr;
        opcodeW        = op;
    endtask

    task automatic modelReset();
        for (int i = 0; i < 32; i++) mreg[i] = 32'h0;
        mcnt = 32'h0;
    endtask

    initial begin
        logic [5:0] ops [7];
        logic [31:0] oldVal;
        ops[0] = 6'h03; ops[1] = 6'h20; ops[2] = 6'h21; ops[3] = 6'h23;
        ops[4] = 6'h24; ops[5] = 6'h25; ops[6] = 6'h00;
        total = 0;
        bad   = 0;
        modelReset();
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 6'h00);
        ReadReg1 = 5'd5;
        ReadReg2 = 5'd0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset.count", retiredCount, 32'h0);
        check("reset.rd1", ReadData1, 32'h0);

        // ALU writeback to r5
        drive(1'b1, 1'b0, 32'h0, 32'h1234_5678, 32'h0, 32'h1, 5'd5, 6'h00);
        #1;
        checkAll("alu.pre");
        tick();
        RegWriteW = 1'b0;
        #1;
        check("alu.r5", ReadData1, 32'h1234_5678);

        // Load extraction
        drive(1'b0, 1'b1, 32'h80FF_7F01, 32'h0000_1003, 32'h0, 32'h0, 5'd0, 6'h20);
        #1;
        check("lb.off3", ResultW, 32'hFFFF_FF80);
        opcodeW = 6'h24;
        #1;
        check("lbu.off3", ResultW, 32'h0000_0080);
        opcodeW = 6'h21;
        ALUOutW = 32'h0000_1002;
        #1;
        check("lh.off2", ResultW, 32'hFFFF_80FF);
        opcodeW = 6'h25;
        #1;
        check("lhu.off2", ResultW, 32'h0000_80FF);
        opcodeW = 6'h23;
        #1;
        check("lw", ResultW, 32'h80FF_7F01);

        // jal to r31 takes priority over the load select
        drive(1'b1, 1'b1, 32'h55, 32'h77, 32'h0040_0008, 32'h2, 5'd31, 6'h03);
        ReadReg1 = 5'd31;
        #1;
        check("jal.result", ResultW, 32'h0040_0008);
        tick();
        drive(1'b1, 1'b0, 32'h0, 32'hDEAD_BEEF, 32'h0, 32'h3, 5'd0, 6'h00);
        ReadReg2 = 5'd0;
        #1;
        check("jal.r31", ReadData1, 32'h0040_0008);
        check("r0.same", ReadData2, 32'h0);
        tick();
        RegWriteW = 1'b0;
        ReadReg1  = 5'd0;
        #1;
        check("r0.rd1", ReadData1, 32'h0);
        check("r0.rd2", ReadData2, 32'h0);

        // Same-cycle write/read of r7
        drive(1'b1, 1'b0, 32'h0, 32'h1111_1111, 32'h0, 32'h4, 5'd7, 6'h00);
        tick();
        drive(1'b1, 1'b0, 32'h0, 32'hA5A5_A5A5, 32'h0, 32'h5, 5'd7, 6'h00);
        ReadReg2 = 5'd7;
        #1;
`ifdef WRITEBACK_REGFILE_BYPASS_EN
        oldVal = 32'hA5A5_A5A5;
`else
        oldVal = 32'h1111_1111;
`endif
        check("bypass.r7", ReadData2, oldVal);
        tick();
        RegWriteW = 1'b0;
        #1;
        check("after.r7", ReadData2, 32'hA5A5_A5A5);

        // Counter wrap from the all-ones state
        force dut.retiredCountQ = 32'hFFFF_FFFF;
        #1;
        release dut.retiredCountQ;
        mcnt = 32'hFFFF_FFFF;
        #1;
        check("cnt.preload", retiredCount, 32'hFFFF_FFFF);
        instrW = 32'h0000_0013;
        tick();
        #1;
        check("cnt.wrap", retiredCount, 32'h0);
        instrW = 32'h0;
        tick();
        tick();
        #1;
        check("cnt.bubble", retiredCount, 32'h0);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 3) != 0), $urandom_range(0, 1), $urandom, $urandom,
                  $urandom, ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom,
                  5'($urandom_range(0, 31)), ops[$urandom_range(0, 6)]);
            ReadReg1 = ($urandom_range(0, 3) == 0) ? WriteRegW : 5'($urandom_range(0, 31));
            ReadReg2 = ($urandom_range(0, 3) == 0) ? ReadReg1 : 5'($urandom_range(0, 31));
            #1;
            checkAll("rand");
            if (ReadReg1 == ReadReg2) check("rand.same", ReadData1, ReadData2);
            tick();
        end

        // Mid-cycle asynchronous reset after writes
        drive(1'b1, 1'b0, 32'h0, 32'hCAFE_0009, 32'h0, 32'h6, 5'd9, 6'h00);
        tick();
        @(posedge clk);
        mreg[9] = 32'hCAFE_0009;
        mcnt = mcnt + 32'd1;
        #10;
        drive(1'b1, 1'b0, 32'h0, 32'hBAD0_0009, 32'h0, 32'h7, 5'd9, 6'h00);
        rst_n = 1'b0;
        modelReset();
        #1;
        check("arst.count", retiredCount, 32'h0);
        for (int i = 0; i < 32; i++) begin
            ReadReg1 = 5'(i);
            ReadReg2 = 5'(31 - i);
            #1;
            check("arst.rd1", ReadData1, 32'h0);
            check("arst.rd2", ReadData2, 32'h0);
        end
        ReadReg1 = 5'd9;
        tick();
        #1;
        check("arst.held.r9", ReadData1, 32'h0);
        check("arst.held.count", retiredCount, 32'h0);
        rst_n = 1'b1;
        #1;
        checkAll("arst.release");
        tick();
        RegWriteW = 1'b0;
        #1;
        check("arst.first.r9", ReadData1, 32'hBAD0_0009);
        check("arst.first.count", retiredCount, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
